prog_ram_loader: RTL
====================

Name: prog_ram_loader

Overview:
- Parametrised successor to the SAP-style program/data RAM.
- CPU-facing bus port: synchronous write, combinational read, and an operand-only read mode of configurable field width.
- Adds a bulk loader port with valid/ready handshake and an auto-incrementing pointer.
- Adds a zero-fill clear mode driven by a small FSM, so programs can be loaded or memory wiped while the CPU is halted.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, address bits used; DEPTH = 2**ADDR_WIDTH words.
- OPERAND_WIDTH, 4, low-order operand field returned in operand-only mode; must be <= DATA_WIDTH.

Ports:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_we  in  1  CPU write enable.
- i_operand_only  in  1  read returns zero-extended operand field only.
- i_addr  in  DATA_WIDTH  CPU address; only bits [ADDR_WIDTH-1:0] used.
- i_bus_data  in  DATA_WIDTH  CPU write data.
- o_bus_data  out  DATA_WIDTH  CPU read data.
- i_ld_start  in  1  start loader (IDLE) or terminate load early (LOAD).
- i_ld_clear  in  1  sampled with i_ld_start in IDLE: 1 = zero-fill, 0 = stream load.
- i_ld_valid  in  1  loader data valid.
- i_ld_data  in  DATA_WIDTH  loader data.
- o_ld_ready  out  1  loader accepts a word this cycle.
- o_ld_busy  out  1  loader owns memory.
- o_ld_done  out  1  single-cycle completion pulse.
- o_ld_count  out  ADDR_WIDTH+1  words written in the current or last loader run.

Behaviour:
- Read path (combinational):
  - o_bus_data = mem[i_addr[ADDR_WIDTH-1:0]].
  - If i_operand_only: upper DATA_WIDTH-OPERAND_WIDTH bits are forced to 0; low OPERAND_WIDTH bits pass through.
  - Upper address bits are ignored, so addr 8'h13 with ADDR_WIDTH=4 reads word 3.
- CPU write path:
  - When i_we=1 and the FSM is in IDLE, mem[addr] <= i_bus_data at the clock edge.
  - i_we is ignored in every other state.
- FSM states: IDLE, CLEAR, LOAD, DONE. o_ld_busy = (state != IDLE).
- IDLE:
  - If i_ld_start=1: ptr <= 0, count <= 0; go to CLEAR if i_ld_clear=1, otherwise LOAD.
  - A CPU write in the same cycle as i_ld_start is still performed.
- CLEAR:
  - Every cycle: mem[ptr] <= 0, ptr++, count++.
  - The cycle that writes ptr == DEPTH-1 transitions to DONE.
  - Exactly DEPTH cycles; i_ld_start and i_ld_valid are ignored.
- LOAD:
  - o_ld_ready=1 (combinational from state).
  - On i_ld_valid && o_ld_ready: mem[ptr] <= i_ld_data, ptr++, count++.
  - A write at ptr == DEPTH-1 transitions to DONE; no wrap-around, so word 0 is never overwritten by the same run.
  - i_ld_start=1 transitions to DONE (early terminate). If i_ld_valid is also high that cycle, that word is written first and counted.
  - Gaps in i_ld_valid are allowed; there is no timeout.
- DONE: o_ld_done=1 for exactly this one cycle, o_ld_ready=0; next state IDLE.
- o_ld_count holds its value in IDLE until the next start. A full run yields DEPTH (16 at defaults).
- Reset:
  - state=IDLE, ptr=0, count=0; o_ld_ready=0, o_ld_busy=0, o_ld_done=0, o_ld_count=0.
  - Memory contents are NOT cleared by reset.
  - Reset mid-CLEAR or mid-LOAD aborts immediately; words already written are retained; no done pulse.
- Reset has priority over all other inputs in the same cycle.

Test Plan:
- CPU write/read: write 8'hA7 to addr 5; read addr 5 gives 8'hA7; read with i_operand_only=1 gives 8'h07; read addr 8'h15 gives 8'hA7.
- Full stream load: start with clear=0, stream 16 words 8'h10..8'h1F with valid held high:
  - ready high for 16 cycles, then a done pulse 1 cycle later;
  - count=16, mem[i]=8'h10+i.
- Backpressure/gaps and early stop: in LOAD send 8'hAA, idle 3 cycles, send 8'hBB, then assert start:
  - mem[0]=8'hAA, mem[1]=8'hBB, count=2, done pulses once;
  - mem[2..15] unchanged.
- Clear mode: preload nonzero data, then start with clear=1:
  - busy high for 17 cycles (16 CLEAR + DONE), all words 0, count=16;
  - i_we=1 with data 8'hFF at addr 3 during CLEAR is ignored, so mem[3]=0.
- Reset mid-load: after 3 LOAD writes assert i_rst for 1 cycle:
  - state IDLE, all outputs 0, no done pulse;
  - mem[0..2] retain the loaded data.
- Simultaneous events:
  - start and i_we in IDLE: the CPU write lands and LOAD begins next cycle.
  - valid and start in the same LOAD cycle: the word is written, count includes it, then DONE.

Source files
------------

// File: rtl/prog_ram_loader.sv
// Program/data RAM with a CPU bus port and a bulk loader.
// The loader can stream words in or zero-fill the whole array while the CPU is halted.
module prog_ram_loader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int OPERAND_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic                  i_operand_only,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_bus_data,
  output logic [DATA_WIDTH-1:0] o_bus_data,
  input  logic                  i_ld_start,
  input  logic                  i_ld_clear,
  input  logic                  i_ld_valid,
  input  logic [DATA_WIDTH-1:0] i_ld_data,
  output logic                  o_ld_ready,
  output logic                  o_ld_busy,
  output logic                  o_ld_done,
  output logic [ADDR_WIDTH:0]   o_ld_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [ADDR_WIDTH-1:0]   cpu_addr;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign cpu_addr = i_addr[ADDR_WIDTH-1:0];
  assign rd_word  = mem_q[cpu_addr];

  generate
    if (OPERAND_WIDTH < DATA_WIDTH) begin : g_opmask
      assign o_bus_data = i_operand_only
        ? {{(DATA_WIDTH-OPERAND_WIDTH){1'b0}}, rd_word[OPERAND_WIDTH-1:0]}
        : rd_word;
    end else begin : g_nomask
      assign o_bus_data = rd_word;
    end

    // Upper CPU address bits are deliberately ignored (the memory aliases).
    if (DATA_WIDTH > ADDR_WIDTH) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^i_addr[DATA_WIDTH-1:ADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    mem_we     = 1'b0;
    mem_waddr  = cpu_addr;
    mem_wdata  = i_bus_data;
    o_ld_ready = 1'b0;
    o_ld_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_we = i_we;
        if (i_ld_start) begin
          ptr_d   = '0;
          count_d = '0;
          state_d = i_ld_clear ? S_CLEAR : S_LOAD;
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + PTR_ONE;
        count_d   = count_q + CNT_ONE;
        if (&ptr_q) state_d = S_DONE;
      end
      S_LOAD: begin
        o_ld_ready = 1'b1;
        if (i_ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = i_ld_data;
          ptr_d     = ptr_q + PTR_ONE;
          count_d   = count_q + CNT_ONE;
          // Last word ends the run so the pointer never wraps onto word 0.
          if (&ptr_q) state_d = S_DONE;
        end
        if (i_ld_start) state_d = S_DONE;
      end
      S_DONE: begin
        o_ld_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Contents survive reset; reset only blocks a write landing in the same cycle.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst) mem_q[mem_waddr] <= mem_wdata;
  end

  assign o_ld_busy  = (state_q != S_IDLE);
  assign o_ld_count = count_q;

endmodule
